// File: rtl/lsu_wishbone_pkg.sv
// Shared definitions for the crush load/store unit: funct3 encodings, FSM states
// and the request legality/alignment check.
package lsu_wishbone_pkg;

    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_GAP,
        ST_RESP
    } lsu_state_t;

    // Unsigned loads have no store counterpart, so BU/HU are legal only for loads.
    function automatic logic req_ok(input logic store, input logic [2:0] funct3,
                                    input logic [1:0] addr_lo);
        logic legal;
        logic aligned;
        legal   = 1'b0;
        aligned = 1'b0;
        case (funct3)
            FUNCT3_B:  begin legal = 1'b1;   aligned = 1'b1;            end
            FUNCT3_H:  begin legal = 1'b1;   aligned = ~addr_lo[0];     end
            FUNCT3_W:  begin legal = 1'b1;   aligned = (addr_lo == 2'b00); end
            FUNCT3_BU: begin legal = ~store; aligned = 1'b1;            end
            FUNCT3_HU: begin legal = ~store; aligned = ~addr_lo[0];     end
            default:   begin legal = 1'b0;   aligned = 1'b0;            end
        endcase
        return legal && aligned;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store selects and replicated write data, plus load
// extraction with sign/zero extension.
module lsu_align
    import lsu_wishbone_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        sel       = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = shifted;
        case (funct3[1:0])
            2'b00: begin
                sel       = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                sel       = 4'b0011 << addr_lo;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: ;
        endcase
        case (funct3)
            FUNCT3_B:  rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            FUNCT3_H:  rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
            FUNCT3_BU: rdata_ext = {24'h0, shifted[7:0]};
            FUNCT3_HU: rdata_ext = {16'h0, shifted[15:0]};
            default:   rdata_ext = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_wishbone.sv
// Load/store unit: runs one request per instruction as a Wishbone classic
// master cycle with retry and timeout handling.
module lsu_wishbone
    import lsu_wishbone_pkg::*;
#(
    parameter int RETRY_LIMIT    = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        req_store_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_error_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    output logic [3:0]  sel_o,
    output logic        we_o,
    output logic        stb_o,
    output logic        cyc_o,
    input  logic        ack_i,
    input  logic        err_i,
    input  logic        rty_i
);

    localparam int RW = $clog2(RETRY_LIMIT + 2);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_t    state;
    logic [2:0]    funct3_q;
    logic [1:0]    addr_lo_q;
    logic          store_q;
    logic [RW-1:0] retry_cnt;
    logic [TW-1:0] tmo_cnt;

    logic [2:0]    op_funct3;
    logic [1:0]    op_addr_lo;
    logic [3:0]    al_sel;
    logic [31:0]   al_wdata;
    logic [31:0]   al_rdata;

    // Store lanes come from the live request at accept; load extraction uses the latched fields.
    assign op_funct3  = (state == ST_IDLE) ? req_funct3_i : funct3_q;
    assign op_addr_lo = (state == ST_IDLE) ? req_addr_i[1:0] : addr_lo_q;

    lsu_align u_align (
        .funct3    (op_funct3),
        .addr_lo   (op_addr_lo),
        .wdata     (req_wdata_i),
        .rdata     (dat_i),
        .sel       (al_sel),
        .wdata_rep (al_wdata),
        .rdata_ext (al_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= ST_IDLE;
            req_ready_o  <= 1'b1;
            resp_valid_o <= 1'b0;
            resp_error_o <= 1'b0;
            resp_rdata_o <= '0;
            adr_o        <= '0;
            dat_o        <= '0;
            sel_o        <= '0;
            we_o         <= 1'b0;
            stb_o        <= 1'b0;
            cyc_o        <= 1'b0;
            funct3_q     <= '0;
            addr_lo_q    <= '0;
            store_q      <= 1'b0;
            retry_cnt    <= '0;
            tmo_cnt      <= '0;
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values.
            case (state)
                ST_IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        req_ready_o <= 1'b0;
                        funct3_q    <= req_funct3_i;
                        addr_lo_q   <= req_addr_i[1:0];
                        store_q     <= req_store_i;
                        retry_cnt   <= '0;
                        tmo_cnt     <= '0;
                        if (req_ok(req_store_i, req_funct3_i, req_addr_i[1:0])) begin
                            adr_o <= {req_addr_i[31:2], 2'b00};
                            sel_o <= al_sel;
                            dat_o <= req_store_i ? al_wdata : 32'h0;
                            we_o  <= req_store_i;
                            cyc_o <= 1'b1;
                            stb_o <= 1'b1;
                            state <= ST_BUS;
                        end else begin
                            resp_valid_o <= 1'b1;
                            resp_error_o <= 1'b1;
                            resp_rdata_o <= '0;
                            state        <= ST_RESP;
                        end
                    end
                end
                ST_BUS: begin
                    if (err_i || ack_i) begin
                        cyc_o        <= 1'b0;
                        stb_o        <= 1'b0;
                        resp_valid_o <= 1'b1;
                        resp_error_o <= err_i;
                        resp_rdata_o <= (err_i || store_q) ? 32'h0 : al_rdata;
                        state        <= ST_RESP;
                    end else if (rty_i) begin
                        cyc_o <= 1'b0;
                        stb_o <= 1'b0;
                        if (retry_cnt == RW'(RETRY_LIMIT)) begin
                            resp_valid_o <= 1'b1;
                            resp_error_o <= 1'b1;
                            resp_rdata_o <= '0;
                            state        <= ST_RESP;
                        end else begin
                            retry_cnt <= retry_cnt + RW'(1);
                            state     <= ST_GAP;
                        end
                    end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        cyc_o        <= 1'b0;
                        stb_o        <= 1'b0;
                        resp_valid_o <= 1'b1;
                        resp_error_o <= 1'b1;
                        resp_rdata_o <= '0;
                        state        <= ST_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                ST_GAP: begin
                    cyc_o   <= 1'b1;
                    stb_o   <= 1'b1;
                    tmo_cnt <= '0;
                    state   <= ST_BUS;
                end
                ST_RESP: begin
                    resp_valid_o <= 1'b0;
                    resp_error_o <= 1'b0;
                    resp_rdata_o <= '0;
                    req_ready_o  <= 1'b1;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_wishbone.sv
// Directed bench for lsu_wishbone: alignment, extension, errors, retry,
// timeout and asynchronous reset, driven and sampled on the falling edge.
module tb_lsu_wishbone;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic        req_store_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_wdata_i;
    logic        resp_valid_o;
    logic [31:0] resp_rdata_o;
    logic        resp_error_o;
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic [3:0]  sel_o;
    logic        we_o;
    logic        stb_o;
    logic        cyc_o;
    logic        ack_i;
    logic        err_i;
    logic        rty_i;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    lsu_wishbone #(.RETRY_LIMIT(3), .TIMEOUT_CYCLES(255)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .req_store_i  (req_store_i),
        .req_funct3_i (req_funct3_i),
        .req_wdata_i  (req_wdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_rdata_o (resp_rdata_o),
        .resp_error_o (resp_error_o),
        .adr_o        (adr_o),
        .dat_o        (dat_o),
        .dat_i        (dat_i),
        .sel_o        (sel_o),
        .we_o         (we_o),
        .stb_o        (stb_o),
        .cyc_o        (cyc_o),
        .ack_i        (ack_i),
        .err_i        (err_i),
        .rty_i        (rty_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic issue(input logic store, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        check("ready_before_req", 32'(req_ready_o), 32'd1);
        req_valid_i  = 1'b1;
        req_store_i  = store;
        req_funct3_i = f3;
        req_addr_i   = addr;
        req_wdata_i  = wdata;
        step();
        req_valid_i  = 1'b0;
    endtask

    // Single zero-wait-state transaction acked in the first strobe cycle.
    task automatic bus_txn(input string tag, input logic store, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rd, input logic [3:0] exp_sel,
                           input logic [31:0] exp_dat, input logic [31:0] exp_rdata);
        issue(store, f3, addr, wdata);
        check({tag, ":stb"}, 32'(stb_o), 32'd1);
        check({tag, ":cyc"}, 32'(cyc_o), 32'd1);
        check({tag, ":adr"}, adr_o, {addr[31:2], 2'b00});
        check({tag, ":sel"}, 32'(sel_o), 32'(exp_sel));
        check({tag, ":we"}, 32'(we_o), 32'(store));
        if (store) check({tag, ":dat"}, dat_o, exp_dat);
        dat_i = rd;
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        check({tag, ":resp_valid"}, 32'(resp_valid_o), 32'd1);
        check({tag, ":resp_error"}, 32'(resp_error_o), 32'd0);
        check({tag, ":rdata"}, resp_rdata_o, exp_rdata);
        check({tag, ":stb_low"}, 32'(stb_o), 32'd0);
        step();
        check({tag, ":pulse_end"}, 32'(resp_valid_o), 32'd0);
    endtask

    task automatic bad_req(input string tag, input logic store, input logic [2:0] f3,
                           input logic [31:0] addr);
        issue(store, f3, addr, 32'hA5A5_A5A5);
        check({tag, ":no_stb"}, 32'(stb_o), 32'd0);
        check({tag, ":no_cyc"}, 32'(cyc_o), 32'd0);
        check({tag, ":resp_valid"}, 32'(resp_valid_o), 32'd1);
        check({tag, ":resp_error"}, 32'(resp_error_o), 32'd1);
        check({tag, ":rdata"}, resp_rdata_o, 32'h0);
        step();
        check({tag, ":pulse_end"}, 32'(resp_valid_o), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int strobes;
        int cnt;
        rst_ni = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; req_store_i = 1'b0;
        req_funct3_i = '0; req_wdata_i = '0; dat_i = '0;
        ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst:stb", 32'(stb_o), 32'd0);
        check("rst:cyc", 32'(cyc_o), 32'd0);
        check("rst:we", 32'(we_o), 32'd0);
        check("rst:resp_valid", 32'(resp_valid_o), 32'd0);
        check("rst:resp_error", 32'(resp_error_o), 32'd0);
        check("rst:adr", adr_o, 32'h0);
        check("rst:dat", dat_o, 32'h0);
        check("rst:sel", 32'(sel_o), 32'h0);
        check("rst:rdata", resp_rdata_o, 32'h0);
        check("rst:ready", 32'(req_ready_o), 32'd1);
        rst_ni = 1'b1;
        step();

        bus_txn("lw",  1'b0, 3'b010, 32'h2000_0004, 32'h0, 32'h0000_0002, 4'b1111, 32'h0, 32'h0000_0002);
        bus_txn("lb",  1'b0, 3'b000, 32'h2000_0003, 32'h0, 32'h8382_8180, 4'b1000, 32'h0, 32'hFFFF_FF83);
        bus_txn("lbu", 1'b0, 3'b100, 32'h2000_0003, 32'h0, 32'h8382_8180, 4'b1000, 32'h0, 32'h0000_0083);
        bus_txn("lh",  1'b0, 3'b001, 32'h2000_0002, 32'h0, 32'h8382_8180, 4'b1100, 32'h0, 32'hFFFF_8382);
        bus_txn("lhu", 1'b0, 3'b101, 32'h2000_0000, 32'h0, 32'h1234_8001, 4'b0011, 32'h0, 32'h0000_8001);
        bus_txn("lb+", 1'b0, 3'b000, 32'h2000_0001, 32'h0, 32'h0000_7F00, 4'b0010, 32'h0, 32'h0000_007F);
        bus_txn("sb",  1'b1, 3'b000, 32'h2000_0001, 32'hF3F2_F1F0, 32'hDEAD_BEEF, 4'b0010, 32'hF0F0_F0F0, 32'h0);
        bus_txn("sh",  1'b1, 3'b001, 32'h2000_0002, 32'hF3F2_F1F0, 32'hDEAD_BEEF, 4'b1100, 32'hF1F0_F1F0, 32'h0);
        bus_txn("sw",  1'b1, 3'b010, 32'h2000_0008, 32'hF3F2_F1F0, 32'hDEAD_BEEF, 4'b1111, 32'hF3F2_F1F0, 32'h0);

        bad_req("lw_mis", 1'b0, 3'b010, 32'h2000_0002);
        bad_req("lh_mis", 1'b0, 3'b001, 32'h2000_0001);
        bad_req("ld_f3_011", 1'b0, 3'b011, 32'h2000_0000);
        bad_req("st_f3_100", 1'b1, 3'b100, 32'h2000_0000);

        // Two retries then ack: three strobes with a one-cycle gap between each.
        issue(1'b0, 3'b010, 32'h2000_0010, 32'h0);
        strobes = 0;
        for (int a = 0; a < 3; a++) begin
            check("rty_ok:stb", 32'(stb_o), 32'd1);
            check("rty_ok:adr", adr_o, 32'h2000_0010);
            if (stb_o) strobes++;
            if (a < 2) begin
                rty_i = 1'b1;
                step();
                rty_i = 1'b0;
                check("rty_ok:gap", 32'(cyc_o), 32'd0);
                step();
            end
        end
        dat_i = 32'h0000_0055;
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        check("rty_ok:strobes", 32'(strobes), 32'd3);
        check("rty_ok:resp_valid", 32'(resp_valid_o), 32'd1);
        check("rty_ok:resp_error", 32'(resp_error_o), 32'd0);
        check("rty_ok:rdata", resp_rdata_o, 32'h0000_0055);
        step();

        // Four retries exhaust the limit of three re-issues.
        issue(1'b1, 3'b010, 32'h2000_0014, 32'h1357_9BDF);
        for (int a = 0; a < 4; a++) begin
            check("rty_lim:stb", 32'(stb_o), 32'd1);
            check("rty_lim:dat", dat_o, 32'h1357_9BDF);
            rty_i = 1'b1;
            step();
            rty_i = 1'b0;
            if (a < 3) begin
                check("rty_lim:gap", 32'(stb_o), 32'd0);
                check("rty_lim:no_resp", 32'(resp_valid_o), 32'd0);
                step();
            end
        end
        check("rty_lim:resp_valid", 32'(resp_valid_o), 32'd1);
        check("rty_lim:resp_error", 32'(resp_error_o), 32'd1);
        step();

        // err beats ack beats rty on the same edge.
        issue(1'b0, 3'b010, 32'h2000_0018, 32'h0);
        dat_i = 32'h1111_2222;
        err_i = 1'b1; ack_i = 1'b1; rty_i = 1'b1;
        step();
        err_i = 1'b0; ack_i = 1'b0; rty_i = 1'b0;
        check("prio_err:resp_error", 32'(resp_error_o), 32'd1);
        check("prio_err:rdata", resp_rdata_o, 32'h0);
        step();
        issue(1'b0, 3'b010, 32'h2000_001C, 32'h0);
        dat_i = 32'h3333_4444;
        ack_i = 1'b1; rty_i = 1'b1;
        step();
        ack_i = 1'b0; rty_i = 1'b0;
        check("prio_ack:resp_valid", 32'(resp_valid_o), 32'd1);
        check("prio_ack:resp_error", 32'(resp_error_o), 32'd0);
        check("prio_ack:rdata", resp_rdata_o, 32'h3333_4444);
        step();

        // Silent slave: strobe held for exactly TIMEOUT_CYCLES cycles.
        issue(1'b0, 3'b010, 32'h2000_0020, 32'h0);
        cnt = 0;
        for (int i = 0; i < 400 && stb_o; i++) begin
            cnt++;
            step();
        end
        check("tmo:len", 32'(cnt), 32'd255);
        check("tmo:resp_valid", 32'(resp_valid_o), 32'd1);
        check("tmo:resp_error", 32'(resp_error_o), 32'd1);
        step();

        // Reset during an active strobe.
        issue(1'b0, 3'b010, 32'h2000_0024, 32'h0);
        check("arst:stb_before", 32'(stb_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        check("arst:cyc", 32'(cyc_o), 32'd0);
        check("arst:stb", 32'(stb_o), 32'd0);
        check("arst:ready", 32'(req_ready_o), 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        check("arst:no_resp", 32'(resp_valid_o), 32'd0);

        bus_txn("post_rst", 1'b0, 3'b010, 32'h2000_0028, 32'h0, 32'hCAFE_F00D, 4'b1111, 32'h0, 32'hCAFE_F00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
